// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART timing generator.
// Divisors are unsigned fixed point: clk cycles per oversample tick.
package uart_pkg;

  localparam int unsigned MIN_DIV_INT = 2;

  function automatic longint unsigned calc_div(
    input longint unsigned clk_rate,
    input longint unsigned baud,
    input longint unsigned os,
    input longint unsigned frac_w
  );
    return (clk_rate << frac_w) / (baud * os);
  endfunction

endpackage

// File: rtl/frac_divider.sv
// Fractional-N counter: periods of int or int+1 cycles averaging the divisor.
// tick_o flags the terminal-count cycle; the caller registers it.
module frac_divider
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter logic [DIV_W+FRAC_W-1:0] DIV_RESET = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [DIV_W+FRAC_W-1:0] load_div_i,
  output logic                    tick_o
);

  localparam int unsigned DV_W = DIV_W + FRAC_W;

  logic [DV_W-1:0]   div_q, div_d;
  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [DIV_W:0]    limit_q, limit_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum_s;
  logic              term_s;

  function automatic logic [DIV_W:0] base_limit(input logic [DV_W-1:0] d);
    return {1'b0, d[DV_W-1:FRAC_W]} - {{DIV_W{1'b0}}, 1'b1};
  endfunction

  // >= rather than == so a smaller divisor loaded while held still terminates
  assign term_s = (cnt_q >= limit_q);
  assign sum_s  = {1'b0, acc_q} + {1'b0, div_q[FRAC_W-1:0]};
  assign tick_o = en_i & ~clear_i & term_s;

  // Next-state for count, accumulator, limit and active divisor
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    limit_d = limit_q;
    if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
      if (load_i) begin
        div_d   = load_div_i;
        limit_d = base_limit(load_div_i);
      end else begin
        limit_d = base_limit(div_q);
      end
    end else begin
      if (en_i) begin
        if (term_s) begin
          cnt_d   = '0;
          acc_d   = sum_s[FRAC_W-1:0];
          limit_d = base_limit(div_q) + {{DIV_W{1'b0}}, sum_s[FRAC_W]};
        end else begin
          cnt_d = cnt_q + (DIV_W+1)'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
      if (load_i) begin
        div_d   = load_div_i;
        acc_d   = '0;
        limit_d = base_limit(load_div_i);
      end else begin
        div_d = div_q;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= DIV_RESET;
      cnt_q   <= '0;
      acc_q   <= '0;
      limit_q <= base_limit(DIV_RESET);
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: rtl/uart_tick_gen.sv
// UART timing generator: oversample, mid-bit and baud clock-enable strobes
// with a reloadable fractional divisor and start-bit phase resync.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 9600000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4,
  localparam int unsigned IDX_W     = $clog2(OVERSAMPLE),
  localparam int unsigned DV_W      = DIV_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             resync_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  input  logic [DV_W-1:0]  div_value_i,
  output logic             div_err_o,
  output logic             sample_tick_o,
  output logic             mid_tick_o,
  output logic             baud_tick_o,
  output logic [IDX_W-1:0] sample_idx_o
);

  localparam logic [DV_W-1:0]  DIV_DEFAULT = DV_W'(calc_div(CLK_RATE, BAUD_RATE, OVERSAMPLE, FRAC_W));
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_MID     = IDX_W'(OVERSAMPLE / 2 - 1);

  logic [DV_W-1:0]  pend_div_q, pend_div_d;
  logic             div_ready_q, div_ready_d;
  logic             div_err_q, div_err_d;
  logic             sample_tick_q, sample_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             baud_tick_q, baud_tick_d;
  logic [IDX_W-1:0] sample_idx_q, sample_idx_d;
  logic [IDX_W-1:0] idx_cnt_q, idx_cnt_d;

  logic             term_s;
  logic             apply_s;
  logic             clamp_s;
  logic [DV_W-1:0]  apply_div_s;

  // A pending divisor (div_ready low) takes effect at a bit boundary, on resync, or while idle
  assign apply_s     = ~div_ready_q & (resync_i | ~enable_i | (term_s & (idx_cnt_q == IDX_LAST)));
  assign clamp_s     = (pend_div_q[DV_W-1:FRAC_W] < DIV_W'(MIN_DIV_INT));
  assign apply_div_s = clamp_s ? {DIV_W'(MIN_DIV_INT), {FRAC_W{1'b0}}} : pend_div_q;

  frac_divider #(
    .DIV_W     (DIV_W),
    .FRAC_W    (FRAC_W),
    .DIV_RESET (DIV_DEFAULT)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .en_i       (enable_i),
    .clear_i    (resync_i),
    .load_i     (apply_s),
    .load_div_i (apply_div_s),
    .tick_o     (term_s)
  );

  // Handshake, sample index and tick decode next-state
  always_comb begin
    pend_div_d  = pend_div_q;
    div_ready_d = div_ready_q;
    if (apply_s) begin
      div_ready_d = 1'b1;
    end else if (div_valid_i && div_ready_q) begin
      pend_div_d  = div_value_i;
      div_ready_d = 1'b0;
    end else begin
      div_ready_d = div_ready_q;
    end

    div_err_d     = apply_s & clamp_s;
    sample_tick_d = term_s;
    mid_tick_d    = term_s & (idx_cnt_q == IDX_MID);
    baud_tick_d   = term_s & (idx_cnt_q == IDX_LAST);

    sample_idx_d = sample_idx_q;
    idx_cnt_d    = idx_cnt_q;
    if (resync_i) begin
      sample_idx_d = '0;
      idx_cnt_d    = '0;
    end else if (term_s) begin
      sample_idx_d = idx_cnt_q;
      idx_cnt_d    = idx_cnt_q + IDX_W'(1);
    end else begin
      sample_idx_d = sample_idx_q;
      idx_cnt_d    = idx_cnt_q;
    end
  end

  // Output and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_div_q    <= '0;
      div_ready_q   <= 1'b1;
      div_err_q     <= 1'b0;
      sample_tick_q <= 1'b0;
      mid_tick_q    <= 1'b0;
      baud_tick_q   <= 1'b0;
      sample_idx_q  <= '0;
      idx_cnt_q     <= '0;
    end else begin
      pend_div_q    <= pend_div_d;
      div_ready_q   <= div_ready_d;
      div_err_q     <= div_err_d;
      sample_tick_q <= sample_tick_d;
      mid_tick_q    <= mid_tick_d;
      baud_tick_q   <= baud_tick_d;
      sample_idx_q  <= sample_idx_d;
      idx_cnt_q     <= idx_cnt_d;
    end
  end

  assign div_ready_o   = div_ready_q;
  assign div_err_o     = div_err_q;
  assign sample_tick_o = sample_tick_q;
  assign mid_tick_o    = mid_tick_q;
  assign baud_tick_o   = baud_tick_q;
  assign sample_idx_o  = sample_idx_q;

endmodule
